// File: rtl/gcc_phat_pkg.sv
// Shared definitions for the complex/real sample stream blocks: sample widths,
// lane slicing helper, occupancy states and the shift-and-saturate function.
package gcc_phat_pkg;

  localparam int SAMPLE_WIDTH = 16;
  localparam int COMP_WIDTH   = 16;
  localparam int WIDE_W       = 64;

  // Result of a shift-and-saturate: clamped value (wide) plus a saturation hit
  typedef struct packed {
    logic              sat;
    logic [WIDE_W-1:0] value;
  } sat_result_t;

  // Data-path occupancy of a two-entry skid buffer
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_t;

  // Bit offset of lane 'lane' in a bus of 'width'-bit lanes
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // Arithmetic right shift (floor), then clamp to an out_w-bit signed range
  function automatic sat_result_t sat_shift(input logic signed [WIDE_W-1:0] re,
                                            input int shift,
                                            input int out_w);
    logic signed [WIDE_W-1:0] v;
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    sat_result_t              r;
    v  = re >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi) begin
      r.sat   = 1'b1;
      r.value = hi;
    end else if (v < lo) begin
      r.sat   = 1'b1;
      r.value = lo;
    end else begin
      r.sat   = 1'b0;
      r.value = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice: registered output stage plus one skid
// entry, so the upstream ready is a register and throughput is 1 beat/cycle.
module axis_skid_buffer
  import gcc_phat_pkg::*;
#(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  occ_state_t       state_r;
  occ_state_t       state_next_s;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] skid_r;
  logic             valid_r;
  logic             ready_r;
  logic             accept_s;
  logic             load_out_s;
  logic             load_skid_s;
  logic             move_skid_s;

  assign accept_s = s_valid & ready_r;
  assign s_ready  = ready_r;
  assign m_data   = out_r;
  assign m_valid  = valid_r;

  // Next occupancy and which register captures data this cycle
  always_comb begin
    state_next_s = state_r;
    load_out_s   = 1'b0;
    load_skid_s  = 1'b0;
    move_skid_s  = 1'b0;
    case (state_r)
      OCC_EMPTY: begin
        if (accept_s) begin
          load_out_s   = 1'b1;
          state_next_s = OCC_ONE;
        end else begin
          state_next_s = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (accept_s && m_ready) begin
          load_out_s   = 1'b1;
          state_next_s = OCC_ONE;
        end else if (accept_s) begin
          load_skid_s  = 1'b1;
          state_next_s = OCC_TWO;
        end else if (m_ready) begin
          state_next_s = OCC_EMPTY;
        end else begin
          state_next_s = OCC_ONE;
        end
      end
      OCC_TWO: begin
        if (m_ready) begin
          move_skid_s  = 1'b1;
          state_next_s = OCC_ONE;
        end else begin
          state_next_s = OCC_TWO;
        end
      end
      default: begin
        state_next_s = OCC_EMPTY;
      end
    endcase
  end

  // Occupancy register with registered valid/ready derived from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= OCC_EMPTY;
      valid_r <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      valid_r <= (state_next_s != OCC_EMPTY);
      ready_r <= (state_next_s != OCC_TWO);
    end
  end

  // Output and skid data registers; output holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r  <= {WIDTH{1'b0}};
      skid_r <= {WIDTH{1'b0}};
    end else begin
      if (load_out_s) begin
        out_r <= s_data;
      end else if (move_skid_s) begin
        out_r <= skid_r;
      end
      if (load_skid_s) begin
        skid_r <= s_data;
      end
    end
  end

endmodule

// File: rtl/samples_deinterleave.sv
// Complex-to-real return path: keeps each lane's real part, shifts and
// saturates it, regenerates frame tlast and tracks sticky framing/saturation
// flags. Output is fully registered through a skid buffer.
module samples_deinterleave
  import gcc_phat_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 16,
  parameter int IN_COMP_WIDTH = 16,
  parameter int COMPLEX_WIDTH = 2 * IN_COMP_WIDTH,
  parameter int CHANNELS      = 4,
  parameter int FRAME_LEN     = 1024,
  parameter int SHIFT         = 0
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [CHANNELS*COMPLEX_WIDTH-1:0] s_axis_complex_tdata,
  input  logic                              s_axis_complex_tvalid,
  output logic                              s_axis_complex_tready,
  input  logic                              s_axis_complex_tlast,
  output logic [CHANNELS*CHANNEL_WIDTH-1:0] m_axis_simple_tdata,
  output logic                              m_axis_simple_tvalid,
  input  logic                              m_axis_simple_tready,
  output logic                              m_axis_simple_tlast,
  output logic                              frame_err,
  output logic                              sat_flag,
  input  logic                              flags_clear
);

  localparam int OUT_W = CHANNELS * CHANNEL_WIDTH;
  localparam int CNT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  logic [OUT_W-1:0]    scaled_s;
  logic [CHANNELS-1:0] lane_sat_s;
  logic                accept_s;
  logic                exp_last_s;
  logic                last_s;
  logic                frame_mis_s;
  logic                sat_evt_s;
  logic [CNT_W-1:0]    beat_cnt_r;
  logic                frame_err_r;
  logic                sat_flag_r;

  assign accept_s = s_axis_complex_tvalid & s_axis_complex_tready;

  // Per-lane real-part extraction, scaling and clamping (imag part dropped)
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    logic [IN_COMP_WIDTH-1:0]  re_s;
    logic signed [WIDE_W-1:0]  re_wide_s;
    sat_result_t               res_s;
    assign re_s      = s_axis_complex_tdata[lane_lsb(i, COMPLEX_WIDTH) +: IN_COMP_WIDTH];
    assign re_wide_s = {{(WIDE_W-IN_COMP_WIDTH){re_s[IN_COMP_WIDTH-1]}}, re_s};
    assign res_s     = sat_shift(re_wide_s, SHIFT, CHANNEL_WIDTH);
    assign scaled_s[lane_lsb(i, CHANNEL_WIDTH) +: CHANNEL_WIDTH] = res_s.value[CHANNEL_WIDTH-1:0];
    assign lane_sat_s[i] = res_s.sat;
  end

  // An upstream tlast always closes the frame, even when it arrives early
  assign exp_last_s  = (beat_cnt_r == LAST_BEAT);
  assign last_s      = exp_last_s | s_axis_complex_tlast;
  assign frame_mis_s = accept_s & (s_axis_complex_tlast != exp_last_s);
  assign sat_evt_s   = accept_s & (|lane_sat_s);

  // Beat position within the frame; resyncs to upstream tlast
  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      if (last_s) begin
        beat_cnt_r <= {CNT_W{1'b0}};
      end else begin
        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      end
    end
  end

  // Sticky flags: a new event in the clearing cycle keeps the flag set
  always_ff @(posedge aclk) begin
    if (areset) begin
      frame_err_r <= 1'b0;
      sat_flag_r  <= 1'b0;
    end else begin
      frame_err_r <= (frame_err_r & ~flags_clear) | frame_mis_s;
      sat_flag_r  <= (sat_flag_r & ~flags_clear) | sat_evt_s;
    end
  end

  assign frame_err = frame_err_r;
  assign sat_flag  = sat_flag_r;

  axis_skid_buffer #(
    .WIDTH (OUT_W + 1)
  ) u_skid (
    .clk     (aclk),
    .rst     (areset),
    .s_data  ({last_s, scaled_s}),
    .s_valid (s_axis_complex_tvalid),
    .s_ready (s_axis_complex_tready),
    .m_data  ({m_axis_simple_tlast, m_axis_simple_tdata}),
    .m_valid (m_axis_simple_tvalid),
    .m_ready (m_axis_simple_tready)
  );

endmodule

// File: tb/tb_samples_deinterleave.sv
// Self-checking bench: table vectors, scoreboard-checked streams, framing,
// shift/saturation variants and reset during a full stall.
module tb_samples_deinterleave;

  localparam int FL   = 1024;
  localparam int SB_N = 16384;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } sb_t;

  typedef struct {
    logic [127:0] din;
    logic [63:0]  exp;
  } vec_t;

  logic         aclk;
  logic         areset;
  logic [127:0] s_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic         s_tlast;
  logic [63:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic         frame_err;
  logic         sat_flag;
  logic         flags_clear;

  logic [127:0] sh_tdata;
  logic         sh_tvalid, sh_tready, sh_mvalid, sh_mlast, sh_ferr, sh_sat;
  logic [63:0]  sh_mdata;
  logic [191:0] wd_tdata;
  logic         wd_tvalid, wd_tready, wd_mvalid, wd_mlast, wd_ferr, wd_sat, wd_clear;
  logic [63:0]  wd_mdata;

  int  checks = 0;
  int  errors = 0;
  sb_t sb [SB_N];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  int  out_cnt = 0;
  int  cyc = 0;
  int  pop_cyc [SB_N];
  int  last_pos [$];
  int  mcnt = 0;
  bit  ready_rand = 1'b0;
  logic ready_val = 1'b1;
  vec_t tbl [4];

  samples_deinterleave dut (
    .aclk(aclk), .areset(areset),
    .s_axis_complex_tdata(s_tdata), .s_axis_complex_tvalid(s_tvalid),
    .s_axis_complex_tready(s_tready), .s_axis_complex_tlast(s_tlast),
    .m_axis_simple_tdata(m_tdata), .m_axis_simple_tvalid(m_tvalid),
    .m_axis_simple_tready(m_tready), .m_axis_simple_tlast(m_tlast),
    .frame_err(frame_err), .sat_flag(sat_flag), .flags_clear(flags_clear)
  );

  samples_deinterleave #(.SHIFT(4)) u_shift (
    .aclk(aclk), .areset(areset),
    .s_axis_complex_tdata(sh_tdata), .s_axis_complex_tvalid(sh_tvalid),
    .s_axis_complex_tready(sh_tready), .s_axis_complex_tlast(1'b0),
    .m_axis_simple_tdata(sh_mdata), .m_axis_simple_tvalid(sh_mvalid),
    .m_axis_simple_tready(1'b1), .m_axis_simple_tlast(sh_mlast),
    .frame_err(sh_ferr), .sat_flag(sh_sat), .flags_clear(1'b0)
  );

  samples_deinterleave #(.IN_COMP_WIDTH(24), .CHANNEL_WIDTH(16)) u_wide (
    .aclk(aclk), .areset(areset),
    .s_axis_complex_tdata(wd_tdata), .s_axis_complex_tvalid(wd_tvalid),
    .s_axis_complex_tready(wd_tready), .s_axis_complex_tlast(1'b0),
    .m_axis_simple_tdata(wd_mdata), .m_axis_simple_tvalid(wd_mvalid),
    .m_axis_simple_tready(1'b1), .m_axis_simple_tlast(wd_mlast),
    .frame_err(wd_ferr), .sat_flag(wd_sat), .flags_clear(wd_clear)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Downstream ready: fixed level or 50% random, changed just after each edge
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      m_tready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Output monitor: scoreboard compare, pop on handshake, valid-drop check
  initial begin
    bit prev_stall;
    prev_stall = 1'b0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (areset) begin
        rd_ptr     = wr_ptr;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!m_tvalid) begin
            errors++;
            $display("FAIL valid_drop: m_tvalid=%b required 1 while stalled", m_tvalid);
          end
        end
        if (m_tvalid) begin
          checks++;
          if (rd_ptr == wr_ptr) begin
            errors++;
            $display("FAIL unexpected_beat: got data=%h last=%b, scoreboard empty", m_tdata, m_tlast);
          end else if (m_tdata !== sb[rd_ptr % SB_N].data || m_tlast !== sb[rd_ptr % SB_N].last) begin
            errors++;
            $display("FAIL beat_%0d: got data=%h last=%b required data=%h last=%b", out_cnt,
                     m_tdata, m_tlast, sb[rd_ptr % SB_N].data, sb[rd_ptr % SB_N].last);
          end
          if (m_tready && rd_ptr != wr_ptr) begin
            if (m_tlast) last_pos.push_back(out_cnt);
            pop_cyc[out_cnt % SB_N] = cyc;
            out_cnt++;
            rd_ptr++;
          end
        end
        prev_stall = m_tvalid & ~m_tready;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic to_phase();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack16(input logic [15:0] r0, input logic [15:0] r1,
                                          input logic [15:0] r2, input logic [15:0] r3,
                                          input logic [15:0] im);
    return {im, r3, im, r2, im, r1, im, r0};
  endfunction

  function automatic logic [191:0] pack24(input logic [23:0] r0, input logic [23:0] r1,
                                          input logic [23:0] r2, input logic [23:0] r3,
                                          input logic [23:0] im);
    return {im, r3, im, r2, im, r1, im, r0};
  endfunction

  function automatic logic [63:0] real_parts(input logic [127:0] din);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = din[i*32 +: 16];
    return r;
  endfunction

  // Drive one beat (called at posedge+1), push expectation on acceptance
  task automatic send_beat(input logic [127:0] din, input logic lst, input logic [63:0] exp_d);
    int  n;
    bit  done;
    sb_t e;
    s_tdata  = din;
    s_tlast  = lst;
    s_tvalid = 1'b1;
    n    = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(negedge aclk);
      if (s_tready) begin
        e.data = exp_d;
        e.last = (mcnt == FL - 1) || lst;
        mcnt   = e.last ? 0 : mcnt + 1;
        sb[wr_ptr % SB_N] = e;
        wr_ptr++;
        done = 1'b1;
      end
      to_phase();
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: s_tready stayed 0 for %0d cycles", n);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (rd_ptr != wr_ptr && n < 500) begin
      to_phase();
      n++;
    end
    chk(name, 64'(rd_ptr == wr_ptr), 64'd1);
  endtask

  task automatic do_reset();
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    mcnt     = 0;
    repeat (2) to_phase();
    areset = 1'b0;
    to_phase();
  endtask

  initial begin
    int base;
    int lbase;
    logic [127:0] d;
    areset = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; flags_clear = 1'b0;
    sh_tdata = '0; sh_tvalid = 1'b0; wd_tdata = '0; wd_tvalid = 1'b0; wd_clear = 1'b0;

    tbl[0] = '{pack16(16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h7FFF), 64'h8000_7FFF_FFFF_0001};
    tbl[1] = '{pack16(16'h0000, 16'h0064, 16'hFF9C, 16'h1234, 16'h8000), 64'h1234_FF9C_0064_0000};
    tbl[2] = '{pack16(16'hFFFE, 16'h0002, 16'h4000, 16'hC000, 16'h0000), 64'hC000_4000_0002_FFFE};
    tbl[3] = '{pack16(16'h5A5A, 16'hA5A5, 16'h0F0F, 16'hF0F0, 16'hFFFF), 64'hF0F0_0F0F_A5A5_5A5A};

    // Reset state
    repeat (3) to_phase();
    @(negedge aclk);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata", m_tdata, 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk("rst_sat_flag", 64'(sat_flag), 64'd0);
    to_phase();
    areset = 1'b0;
    to_phase();
    @(negedge aclk);
    chk("ready_after_reset", 64'(s_tready), 64'd1);
    to_phase();

    // Table vectors, downstream always ready
    for (int k = 0; k < 4; k++) begin
      send_beat(tbl[k].din, 1'b0, tbl[k].exp);
      if (k == 0) begin
        @(negedge aclk);
        chk("latency_valid", 64'(m_tvalid), 64'd1);
        chk("latency_data", m_tdata, tbl[0].exp);
        to_phase();
      end
    end
    drain("table_drain");
    chk("table_sat_flag", 64'(sat_flag), 64'd0);
    chk("table_frame_err", 64'(frame_err), 64'd0);

    // SHIFT=4 instance: floor shift of negative values
    sh_tdata  = pack16(16'hFFEF, 16'h7FFF, 16'hFFFF, 16'h0010, 16'h1234);
    sh_tvalid = 1'b1;
    @(negedge aclk);
    chk("shift_ready", 64'(sh_tready), 64'd1);
    to_phase();
    sh_tvalid = 1'b0;
    @(negedge aclk);
    chk("shift_valid", 64'(sh_mvalid), 64'd1);
    chk("shift_data", sh_mdata, 64'h0001_FFFF_07FF_FFFE);
    chk("shift_sat", 64'(sh_sat), 64'd0);
    to_phase();

    // 24-bit input instance: saturation, clear, and set-wins-over-clear
    wd_tdata  = pack24(24'h400000, 24'h800000, 24'h000064, 24'hFFFFFB, 24'h7FFFFF);
    wd_tvalid = 1'b1;
    @(negedge aclk);
    chk("wide_ready", 64'(wd_tready), 64'd1);
    to_phase();
    wd_tvalid = 1'b0;
    @(negedge aclk);
    chk("wide_data", wd_mdata, 64'hFFFB_0064_8000_7FFF);
    chk("wide_sat_set", 64'(wd_sat), 64'd1);
    to_phase();
    wd_clear = 1'b1;
    to_phase();
    wd_clear = 1'b0;
    @(negedge aclk);
    chk("wide_sat_cleared", 64'(wd_sat), 64'd0);
    to_phase();
    wd_tvalid = 1'b1;
    wd_clear  = 1'b1;
    to_phase();
    wd_tvalid = 1'b0;
    wd_clear  = 1'b0;
    @(negedge aclk);
    chk("wide_sat_set_wins", 64'(wd_sat), 64'd1);
    to_phase();

    // Two full frames back-to-back: tlast on 1023/2047, no bubbles
    do_reset();
    base  = out_cnt;
    lbase = last_pos.size();
    for (int i = 0; i < 2 * FL; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send_beat(d, 1'((i % FL) == FL - 1), real_parts(d));
    end
    drain("b2b_drain");
    chk("b2b_last_count", 64'(last_pos.size() - lbase), 64'd2);
    if (last_pos.size() >= lbase + 2) begin
      chk("b2b_last0_pos", 64'(last_pos[lbase] - base), 64'd1023);
      chk("b2b_last1_pos", 64'(last_pos[lbase+1] - base), 64'd2047);
    end
    chk("b2b_no_bubbles", 64'(pop_cyc[(base + 2*FL - 1) % SB_N] - pop_cyc[base % SB_N]), 64'd2047);
    chk("b2b_frame_err", 64'(frame_err), 64'd0);

    // 5000 beats with random gaps and random downstream ready
    ready_rand = 1'b1;
    base = out_cnt;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 3) == 0) to_phase();
      d = {$urandom, $urandom, $urandom, $urandom};
      send_beat(d, 1'(mcnt == FL - 1), real_parts(d));
    end
    ready_rand = 1'b0;
    ready_val  = 1'b1;
    drain("rand_drain");
    chk("rand_beat_count", 64'(out_cnt - base), 64'd5000);
    chk("rand_frame_err", 64'(frame_err), 64'd0);

    // Early upstream tlast on beat 9: error, forwarded, counter resync
    do_reset();
    base  = out_cnt;
    lbase = last_pos.size();
    for (int i = 0; i < 10; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send_beat(d, 1'(i == 9), real_parts(d));
    end
    to_phase();
    @(negedge aclk);
    chk("early_last_frame_err", 64'(frame_err), 64'd1);
    to_phase();
    flags_clear = 1'b1;
    to_phase();
    flags_clear = 1'b0;
    @(negedge aclk);
    chk("frame_err_cleared", 64'(frame_err), 64'd0);
    to_phase();
    for (int i = 0; i < FL; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send_beat(d, 1'(i == FL - 1), real_parts(d));
    end
    drain("resync_drain");
    chk("resync_last_count", 64'(last_pos.size() - lbase), 64'd2);
    if (last_pos.size() >= lbase + 2) begin
      chk("resync_last0_pos", 64'(last_pos[lbase] - base), 64'd9);
      chk("resync_last1_pos", 64'(last_pos[lbase+1] - base), 64'd1033);
    end
    chk("resync_frame_err", 64'(frame_err), 64'd0);

    // Reset while both entries are held under stall: nothing emitted
    ready_val = 1'b0;
    repeat (2) to_phase();
    do_reset();
    send_beat(tbl[0].din, 1'b0, tbl[0].exp);
    send_beat(tbl[1].din, 1'b0, tbl[1].exp);
    @(negedge aclk);
    chk("two_held_ready", 64'(s_tready), 64'd0);
    chk("two_held_valid", 64'(m_tvalid), 64'd1);
    to_phase();
    areset = 1'b1;
    to_phase();
    areset = 1'b0;
    @(negedge aclk);
    chk("stall_reset_valid", 64'(m_tvalid), 64'd0);
    mcnt = 0;
    to_phase();
    ready_val = 1'b1;
    repeat (6) to_phase();
    @(negedge aclk);
    chk("stall_reset_no_output", 64'(m_tvalid), 64'd0);
    chk("stall_reset_sb_empty", 64'(rd_ptr == wr_ptr), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
